// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer for the 12-bit core.
// Optional RUN-cycle counter output enabled by PCSEQ_CYCLE_CNT_EN.
module pc_sequencer #(
    parameter int D = 12,
    parameter int A = 5
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Stall,
    input  logic [3:0]   Instr,
    input  logic [A-1:0] Tgt_idx,
    input  logic         Alu_zero,
    input  logic         Alu_sign,
    input  logic         Flag_we,
    input  logic [D-1:0] Lut_target,
    output logic [A-1:0] Lut_addr,
    output logic [D-1:0] Prog_ctr,
    output logic         Br_taken,
    output logic         Busy,
`ifdef PCSEQ_CYCLE_CNT_EN
    output logic         Done,
    output logic [15:0]  Cycle_cnt
`else
    output logic         Done
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [3:0] OP_BGE  = 4'b1100;
    localparam logic [3:0] OP_BLE  = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1111;
    localparam logic [D-1:0] PC_ONE = {{(D-1){1'b0}}, 1'b1};

    state_t       r_state;
    state_t       w_next_state;
    logic [D-1:0] r_pc;
    logic [D-1:0] w_pc_d;
    logic         w_pc_we;
    logic         r_zf;
    logic         r_sf;
    logic         w_flag_we;
    logic         w_flag_clr;
    logic         w_adv;
    logic         w_cond;
    logic         w_br;
    logic         w_busy;
    logic         w_done;

    // Branch condition from the registered flags only (no same-cycle bypass).
    always_comb begin
        w_cond = 1'b0;
        if (Instr == OP_BGE)
            w_cond = !r_sf || r_zf;
        else if (Instr == OP_BLE)
            w_cond = r_sf || r_zf;
    end

    // Next-state, PC update and status decode.
    always_comb begin
        w_next_state = r_state;
        w_pc_d       = r_pc;
        w_pc_we      = 1'b0;
        w_flag_we    = 1'b0;
        w_flag_clr   = 1'b0;
        w_adv        = 1'b0;
        w_br         = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (Start) begin
                    w_next_state = RUN;
                    w_pc_d       = '0;
                    w_pc_we      = 1'b1;
                    w_flag_clr   = 1'b1;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                w_br   = w_cond;
                if (!Stall) begin
                    w_adv     = 1'b1;
                    w_flag_we = Flag_we;
                    if (w_cond) begin
                        w_pc_d  = Lut_target;
                        w_pc_we = 1'b1;
                    end else if (Instr == OP_HALT) begin
                        w_next_state = HALTED;
                    end else begin
                        w_pc_d  = r_pc + PC_ONE;
                        w_pc_we = 1'b1;
                    end
                end
            end
            HALTED: begin
                w_done = 1'b1;
                if (Start) begin
                    w_next_state = RUN;
                    w_pc_d       = '0;
                    w_pc_we      = 1'b1;
                    w_flag_clr   = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    // Program counter register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            r_pc <= '0;
        else if (w_pc_we)
            r_pc <= w_pc_d;
    end

    // Zero/sign flag register, cleared on every fresh start.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_zf <= 1'b0;
            r_sf <= 1'b0;
        end else if (w_flag_clr) begin
            r_zf <= 1'b0;
            r_sf <= 1'b0;
        end else if (w_flag_we) begin
            r_zf <= Alu_zero;
            r_sf <= Alu_sign;
        end
    end

`ifdef PCSEQ_CYCLE_CNT_EN
    logic [15:0] r_cnt;

    // Saturating count of unstalled RUN cycles.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            r_cnt <= '0;
        else if (w_flag_clr)
            r_cnt <= '0;
        else if (w_adv && r_cnt != 16'hFFFF)
            r_cnt <= r_cnt + 16'd1;
    end

    assign Cycle_cnt = r_cnt;
`endif

    assign Lut_addr = Tgt_idx;
    assign Prog_ctr = r_pc;
    assign Br_taken = w_br;
    assign Busy     = w_busy;
    assign Done     = w_done;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Covers sequencing, branches, stall/halt, wrap and async reset.
module tb_pc_sequencer;

    localparam int D = 12;
    localparam int A = 5;

    logic         Clk;
    logic         Reset;
    logic         Start;
    logic         Stall;
    logic [3:0]   Instr;
    logic [A-1:0] Tgt_idx;
    logic         Alu_zero;
    logic         Alu_sign;
    logic         Flag_we;
    logic [D-1:0] Lut_target;
    logic [A-1:0] Lut_addr;
    logic [D-1:0] Prog_ctr;
    logic         Br_taken;
    logic         Busy;
    logic         Done;
`ifdef PCSEQ_CYCLE_CNT_EN
    logic [15:0]  Cycle_cnt;
`endif

    int total = 0;
    int bad   = 0;

    pc_sequencer #(.D(D), .A(A)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Stall      (Stall),
        .Instr      (Instr),
        .Tgt_idx    (Tgt_idx),
        .Alu_zero   (Alu_zero),
        .Alu_sign   (Alu_sign),
        .Flag_we    (Flag_we),
        .Lut_target (Lut_target),
        .Lut_addr   (Lut_addr),
        .Prog_ctr   (Prog_ctr),
        .Br_taken   (Br_taken),
        .Busy       (Busy),
`ifdef PCSEQ_CYCLE_CNT_EN
        .Done       (Done),
        .Cycle_cnt  (Cycle_cnt)
`else
        .Done       (Done)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b0; Start = 1'b0; Stall = 1'b0; Instr = 4'h0;
        Tgt_idx = '0; Alu_zero = 1'b0; Alu_sign = 1'b0;
        Flag_we = 1'b0; Lut_target = '0;
        #12;
        chk("rst_pc", 16'(Prog_ctr), 16'h0);
        chk("rst_busy", 16'(Busy), 16'h0);
        chk("rst_done", 16'(Done), 16'h0);
        chk("rst_br", 16'(Br_taken), 16'h0);
        Tgt_idx = 5'd5;
        #1;
        chk("lut_addr", 16'(Lut_addr), 16'h5);
        Reset = 1'b1;

        // 1: start and sequential flow
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk("start_pc", 16'(Prog_ctr), 16'h0);
        chk("start_busy", 16'(Busy), 16'h1);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("seq_pc", 16'(Prog_ctr), 16'(i));
        end
`ifdef PCSEQ_CYCLE_CNT_EN
        chk("cnt_run", Cycle_cnt, 16'd5);
`endif

        // 2: flags sf=1 zf=0, BGE not taken, BLE taken
        Flag_we = 1'b1; Alu_sign = 1'b1; Alu_zero = 1'b0;
        step();
        chk("flag_pc", 16'(Prog_ctr), 16'h6);
        Flag_we = 1'b0;
        Instr = 4'b1100; Tgt_idx = 5'd1; Lut_target = 12'd42;
        #1;
        chk("bge_nt_br", 16'(Br_taken), 16'h0);
        step();
        chk("bge_nt_pc", 16'(Prog_ctr), 16'h7);
        Instr = 4'b1101;
        #1;
        chk("ble_t_br", 16'(Br_taken), 16'h1);
        step();
        chk("ble_t_pc", 16'(Prog_ctr), 16'd42);

        // 3: no bypass of same-cycle flag write
        Instr = 4'b1100; Flag_we = 1'b1; Alu_zero = 1'b1; Alu_sign = 1'b1;
        Lut_target = 12'd39;
        #1;
        chk("nobyp_br", 16'(Br_taken), 16'h0);
        step();
        chk("nobyp_pc", 16'(Prog_ctr), 16'd43);
        Flag_we = 1'b0;
        #1;
        chk("bge_t_br", 16'(Br_taken), 16'h1);
        step();
        chk("bge_t_pc", 16'(Prog_ctr), 16'd39);

        // 4: branch to 7, stalled halt, then restart
        Instr = 4'b1101; Lut_target = 12'd7;
        step();
        chk("to7_pc", 16'(Prog_ctr), 16'd7);
        Instr = 4'b1111; Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", 16'(Prog_ctr), 16'd7);
            chk("stall_busy", 16'(Busy), 16'h1);
        end
        Stall = 1'b0;
        step();
        chk("halt_done", 16'(Done), 16'h1);
        chk("halt_busy", 16'(Busy), 16'h0);
        chk("halt_pc", 16'(Prog_ctr), 16'd7);
        Instr = 4'b0000; Stall = 1'b1;
        step();
        chk("halt_hold", 16'(Prog_ctr), 16'd7);
        chk("halt_hold_d", 16'(Done), 16'h1);
        Stall = 1'b0; Start = 1'b1;
        step();
        Start = 1'b0;
        chk("restart_pc", 16'(Prog_ctr), 16'h0);
        chk("restart_busy", 16'(Busy), 16'h1);
        chk("restart_done", 16'(Done), 16'h0);
`ifdef PCSEQ_CYCLE_CNT_EN
        chk("cnt_clr", Cycle_cnt, 16'd0);
`endif
        // flags cleared: BLE not taken, BGE taken
        Instr = 4'b1101; Lut_target = 12'd100;
        #1;
        chk("clr_ble_br", 16'(Br_taken), 16'h0);
        Instr = 4'b1100;
        #1;
        chk("clr_bge_br", 16'(Br_taken), 16'h1);
        Instr = 4'b0000; Start = 1'b1;
        step();
        Start = 1'b0;
        chk("start_ign", 16'(Prog_ctr), 16'h1);

        // 5: wrap at 2**D-1
        Instr = 4'b1100; Lut_target = 12'hFFE;
        step();
        chk("wrap_a", 16'(Prog_ctr), 16'hFFE);
        Instr = 4'b0000;
        step();
        chk("wrap_b", 16'(Prog_ctr), 16'hFFF);
        step();
        chk("wrap_c", 16'(Prog_ctr), 16'h000);

        // 6: async reset mid-cycle
        Instr = 4'b1100; Lut_target = 12'h02A;
        step();
        chk("pre_rst_pc", 16'(Prog_ctr), 16'h02A);
        #2;
        Reset = 1'b0;
        #1;
        chk("arst_pc", 16'(Prog_ctr), 16'h0);
        chk("arst_busy", 16'(Busy), 16'h0);
        chk("arst_done", 16'(Done), 16'h0);
        chk("arst_br", 16'(Br_taken), 16'h0);
`ifdef PCSEQ_CYCLE_CNT_EN
        chk("arst_cnt", Cycle_cnt, 16'd0);
`endif
        step();
        chk("idle_pc", 16'(Prog_ctr), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the program counter register and sequences instruction fetch for the 12-bit core. Each RUN cycle it advances the PC, or loads a branch target read from the branch-target LUT when a conditional branch is taken on the latched zero/sign flags. It also handles start, stall and halt. It sits between the instruction decoder/ALU and instruction memory, and is the sole driver of the core's PC.

Parameters:
D, 12, PC width in bits; the PC wraps modulo 2**D.
A, 5, branch-target LUT index width (2**A targets).

Ports:
Clk  input  1  system clock, rising-edge.
Reset  input  1  asynchronous, active-low reset.
Start  input  1  one-cycle pulse; begins execution from PC 0.
Stall  input  1  holds PC and flags for the cycle it is high.
Instr  input  4  opcode of the current instruction.
Tgt_idx  input  A  branch-target index field of the current instruction.
Alu_zero  input  1  ALU zero result.
Alu_sign  input  1  ALU sign result.
Flag_we  input  1  latch Alu_zero/Alu_sign into the flag register.
Lut_target  input  D  target returned by the branch-target LUT.
Lut_addr  output  A  index driven to the LUT.
Prog_ctr  output  D  current PC.
Br_taken  output  1  the current instruction is a taken branch.
Busy  output  1  state is RUN.
Done  output  1  state is HALTED.

Behaviour:
- States: IDLE, RUN, HALTED. Encoded internally.
- Reset (async, Reset=0):
  - state=IDLE; Prog_ctr=0.
  - flag register zf=0, sf=0.
  - Busy=0, Done=0, Br_taken=0. Lut_addr follows Tgt_idx combinationally.
- IDLE:
  - Prog_ctr is held.
  - Start=1 → RUN, Prog_ctr<=0.
- RUN, Stall=1: Prog_ctr, flags and state are all held. Br_taken is still evaluated combinationally.
- RUN, Stall=0:
  - Flag_we=1 → zf<=Alu_zero, sf<=Alu_sign.
  - Instr=4'b1100 (BGE): taken when sf==0 or zf==1.
  - Instr=4'b1101 (BLE): taken when sf==1 or zf==1.
  - Taken → Prog_ctr<=Lut_target.
  - Not taken, or any non-branch opcode → Prog_ctr<=Prog_ctr+1 modulo 2**D; 2**D-1 wraps to 0.
  - Instr=4'b1111 (HALT) → HALTED; Prog_ctr is held.
- Branch conditions use the registered flags from prior cycles. A Flag_we in the same cycle affects only later branches; there is no bypass.
- Br_taken is combinational: RUN and branch condition met. Stall does not gate it.
- LUT lookup: Lut_addr=Tgt_idx. Lut_target is combinational from the LUT in the same cycle, so a taken branch costs 1 cycle, the same as sequential flow.
- HALTED:
  - Done=1, Prog_ctr held.
  - Start=1 → RUN with Prog_ctr<=0, flags cleared, Done deasserts next cycle.
- Start in RUN is ignored.
- Stall in IDLE or HALTED has no effect.
- HALT with Stall=1: stall wins; the halt takes effect on the first unstalled cycle.
- Reset mid-RUN: everything returns immediately to reset values. No partial PC update.

Optional Feature:
Macro PCSEQ_CYCLE_CNT_EN.
- Defined:
  - Extra output Cycle_cnt [15:0] counts RUN cycles with Stall=0; saturates at 16'hFFFF.
  - Cleared by reset and by Start from IDLE/HALTED; held in HALTED.
- Undefined: the port and the counter logic are absent.

Test Plan:
1. Reset=0 then 1; Start pulse; Instr=4'b0000 for 5 cycles → Prog_ctr 0,1,2,3,4,5; Busy=1.
2. Flag_we with Alu_sign=1, Alu_zero=0; next cycle Instr=4'b1100, Tgt_idx=1, Lut_target=42 → not taken, PC+1. Instr=4'b1101 with Lut_target=42 → Br_taken=1, next Prog_ctr=42.
3. Flag_we with zero=1 and Instr=4'b1100 in the same cycle, old flags sf=1, zf=0 → not taken (no bypass). Following BGE cycle → taken to Lut_target=39.
4. Stall=1 for 3 cycles at PC=7 with Instr=4'b1111 → PC stays 7, Busy=1. Stall released → HALTED, Done=1, PC=7. Start → PC=0, RUN.
5. Advance PC to 12'hFFF with non-branch opcodes → next Prog_ctr=12'h000.
6. Reset asserted asynchronously mid-cycle at PC=0x2A → Prog_ctr=0, state IDLE, Done=0 immediately. With PCSEQ_CYCLE_CNT_EN: Cycle_cnt=0.
